// File: rtl/pipeline_regs.sv
// ============================================================================
//  Module      : pipeline_regs
//  Description : IF/ID, ID/EX and EX/MEM latches for the 8-bit / 16-bit-PC CPU.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pipeline_regs (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [3:0]  ifid_opcode_i,
    input  logic [1:0]  ifid_format_i,
    input  logic [2:0]  ifid_imm_i,
    input  logic        ifid_immFlag_i,
    input  logic [15:0] ifid_jmpLoc_i,
    input  logic [2:0]  ifid_reg1_i,
    input  logic [2:0]  ifid_reg2_i,
    input  logic [2:0]  ifid_regD_i,
    output logic [3:0]  ifid_opcode_o,
    output logic [1:0]  ifid_format_o,
    output logic [2:0]  ifid_imm_o,
    output logic        ifid_immFlag_o,
    output logic [15:0] ifid_jmpLoc_o,
    output logic [2:0]  ifid_reg1_o,
    output logic [2:0]  ifid_reg2_o,
    output logic [2:0]  ifid_regD_o,

    input  logic        idex_write_mem_i,
    input  logic        idex_write_reg_i,
    input  logic        idex_read_mem_i,
    input  logic [3:0]  idex_alu_op_i,
    input  logic [7:0]  idex_data1_i,
    input  logic [7:0]  idex_data2_i,
    input  logic [7:0]  idex_dataD_i,
    input  logic [2:0]  idex_imm_i,
    input  logic [15:0] idex_jmpLoc_i,
    input  logic [3:0]  idex_opcode_i,
    input  logic [2:0]  idex_reg1_i,
    input  logic [2:0]  idex_reg2_i,
    input  logic [2:0]  idex_regD_i,
    output logic        idex_write_mem_o,
    output logic        idex_write_reg_o,
    output logic        idex_read_mem_o,
    output logic [3:0]  idex_alu_op_o,
    output logic [7:0]  idex_data1_o,
    output logic [7:0]  idex_data2_o,
    output logic [7:0]  idex_dataD_o,
    output logic [2:0]  idex_imm_o,
    output logic [15:0] idex_jmpLoc_o,
    output logic [3:0]  idex_opcode_o,
    output logic [2:0]  idex_reg1_o,
    output logic [2:0]  idex_reg2_o,
    output logic [2:0]  idex_regD_o,

    input  logic        exmem_write_mem_i,
    input  logic        exmem_write_reg_i,
    input  logic        exmem_read_mem_i,
    input  logic [7:0]  exmem_aluOut_i,
    input  logic [7:0]  exmem_data1_i,
    input  logic [7:0]  exmem_data2_i,
    input  logic [7:0]  exmem_dataD_i,
    input  logic [2:0]  exmem_imm_i,
    input  logic [3:0]  exmem_opcode_i,
    input  logic [2:0]  exmem_reg1_i,
    input  logic [2:0]  exmem_reg2_i,
    input  logic [2:0]  exmem_regD_i,
    output logic        exmem_write_mem_o,
    output logic        exmem_write_reg_o,
    output logic        exmem_read_mem_o,
    output logic [7:0]  exmem_aluOut_o,
    output logic [7:0]  exmem_data1_o,
    output logic [7:0]  exmem_data2_o,
    output logic [7:0]  exmem_dataD_o,
    output logic [2:0]  exmem_imm_o,
    output logic [3:0]  exmem_opcode_o,
    output logic [2:0]  exmem_reg1_o,
    output logic [2:0]  exmem_reg2_o,
    output logic [2:0]  exmem_regD_o
);

    localparam int unsigned c_IFID_W  = 35;
    localparam int unsigned c_IDEX_W  = 63;
    localparam int unsigned c_EXMEM_W = 51;

    logic [c_IFID_W-1:0]  ifid_d,  ifid_q;
    logic [c_IDEX_W-1:0]  idex_d,  idex_q;
    logic [c_EXMEM_W-1:0] exmem_d, exmem_q;

    // Each bank is flattened into one word so reset and capture apply uniformly.
    assign ifid_d = {ifid_opcode_i, ifid_format_i, ifid_imm_i, ifid_immFlag_i,
                     ifid_jmpLoc_i, ifid_reg1_i, ifid_reg2_i, ifid_regD_i};

    assign idex_d = {idex_write_mem_i, idex_write_reg_i, idex_read_mem_i,
                     idex_alu_op_i, idex_data1_i, idex_data2_i, idex_dataD_i,
                     idex_imm_i, idex_jmpLoc_i, idex_opcode_i,
                     idex_reg1_i, idex_reg2_i, idex_regD_i};

    assign exmem_d = {exmem_write_mem_i, exmem_write_reg_i, exmem_read_mem_i,
                      exmem_aluOut_i, exmem_data1_i, exmem_data2_i, exmem_dataD_i,
                      exmem_imm_i, exmem_opcode_i,
                      exmem_reg1_i, exmem_reg2_i, exmem_regD_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
        end else begin
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
        end
    end

    assign {ifid_opcode_o, ifid_format_o, ifid_imm_o, ifid_immFlag_o,
            ifid_jmpLoc_o, ifid_reg1_o, ifid_reg2_o, ifid_regD_o} = ifid_q;

    assign {idex_write_mem_o, idex_write_reg_o, idex_read_mem_o,
            idex_alu_op_o, idex_data1_o, idex_data2_o, idex_dataD_o,
            idex_imm_o, idex_jmpLoc_o, idex_opcode_o,
            idex_reg1_o, idex_reg2_o, idex_regD_o} = idex_q;

    assign {exmem_write_mem_o, exmem_write_reg_o, exmem_read_mem_o,
            exmem_aluOut_o, exmem_data1_o, exmem_data2_o, exmem_dataD_o,
            exmem_imm_o, exmem_opcode_o,
            exmem_reg1_o, exmem_reg2_o, exmem_regD_o} = exmem_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_regs.sv
// Testbench for pipeline_regs: directed vectors, bench-side model of the three
// latches (with optional bench-level chaining) and per-cycle comparison.
`default_nettype none
`timescale 1ns/1ps

module tb_pipeline_regs;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [1:0]  format;
        logic [2:0]  imm;
        logic        immFlag;
        logic [15:0] jmpLoc;
        logic [2:0]  reg1;
        logic [2:0]  reg2;
        logic [2:0]  regD;
    } ifid_t;

    typedef struct packed {
        logic        wm;
        logic        wr;
        logic        rm;
        logic [3:0]  alu_op;
        logic [7:0]  data1;
        logic [7:0]  data2;
        logic [7:0]  dataD;
        logic [2:0]  imm;
        logic [15:0] jmpLoc;
        logic [3:0]  opcode;
        logic [2:0]  reg1;
        logic [2:0]  reg2;
        logic [2:0]  regD;
    } idex_t;

    typedef struct packed {
        logic        wm;
        logic        wr;
        logic        rm;
        logic [7:0]  aluOut;
        logic [7:0]  data1;
        logic [7:0]  data2;
        logic [7:0]  dataD;
        logic [2:0]  imm;
        logic [3:0]  opcode;
        logic [2:0]  reg1;
        logic [2:0]  reg2;
        logic [2:0]  regD;
    } exmem_t;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    logic   chain = 1'b0;
    ifid_t  drv_ifid;
    idex_t  drv_idex;
    exmem_t drv_exmem;
    idex_t  in_idex;
    exmem_t in_exmem;
    ifid_t  out_ifid;
    idex_t  out_idex;
    exmem_t out_exmem;
    ifid_t  m_ifid  = '0;
    idex_t  m_idex  = '0;
    exmem_t m_exmem = '0;
    int     compared   = 0;
    int     mismatched = 0;

    always #5 clk = ~clk;

    // Bench-level chaining: IF/ID feeds ID/EX, ID/EX feeds EX/MEM.
    always_comb begin
        in_idex = drv_idex;
        if (chain) begin
            in_idex.imm    = out_ifid.imm;
            in_idex.jmpLoc = out_ifid.jmpLoc;
            in_idex.opcode = out_ifid.opcode;
            in_idex.reg1   = out_ifid.reg1;
            in_idex.reg2   = out_ifid.reg2;
            in_idex.regD   = out_ifid.regD;
        end
    end

    always_comb begin
        in_exmem = drv_exmem;
        if (chain) begin
            in_exmem.wm     = out_idex.wm;
            in_exmem.wr     = out_idex.wr;
            in_exmem.rm     = out_idex.rm;
            in_exmem.data1  = out_idex.data1;
            in_exmem.data2  = out_idex.data2;
            in_exmem.dataD  = out_idex.dataD;
            in_exmem.imm    = out_idex.imm;
            in_exmem.opcode = out_idex.opcode;
            in_exmem.reg1   = out_idex.reg1;
            in_exmem.reg2   = out_idex.reg2;
            in_exmem.regD   = out_idex.regD;
        end
    end

    pipeline_regs dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ifid_opcode_i     (drv_ifid.opcode),
        .ifid_format_i     (drv_ifid.format),
        .ifid_imm_i        (drv_ifid.imm),
        .ifid_immFlag_i    (drv_ifid.immFlag),
        .ifid_jmpLoc_i     (drv_ifid.jmpLoc),
        .ifid_reg1_i       (drv_ifid.reg1),
        .ifid_reg2_i       (drv_ifid.reg2),
        .ifid_regD_i       (drv_ifid.regD),
        .ifid_opcode_o     (out_ifid.opcode),
        .ifid_format_o     (out_ifid.format),
        .ifid_imm_o        (out_ifid.imm),
        .ifid_immFlag_o    (out_ifid.immFlag),
        .ifid_jmpLoc_o     (out_ifid.jmpLoc),
        .ifid_reg1_o       (out_ifid.reg1),
        .ifid_reg2_o       (out_ifid.reg2),
        .ifid_regD_o       (out_ifid.regD),
        .idex_write_mem_i  (in_idex.wm),
        .idex_write_reg_i  (in_idex.wr),
        .idex_read_mem_i   (in_idex.rm),
        .idex_alu_op_i     (in_idex.alu_op),
        .idex_data1_i      (in_idex.data1),
        .idex_data2_i      (in_idex.data2),
        .idex_dataD_i      (in_idex.dataD),
        .idex_imm_i        (in_idex.imm),
        .idex_jmpLoc_i     (in_idex.jmpLoc),
        .idex_opcode_i     (in_idex.opcode),
        .idex_reg1_i       (in_idex.reg1),
        .idex_reg2_i       (in_idex.reg2),
        .idex_regD_i       (in_idex.regD),
        .idex_write_mem_o  (out_idex.wm),
        .idex_write_reg_o  (out_idex.wr),
        .idex_read_mem_o   (out_idex.rm),
        .idex_alu_op_o     (out_idex.alu_op),
        .idex_data1_o      (out_idex.data1),
        .idex_data2_o      (out_idex.data2),
        .idex_dataD_o      (out_idex.dataD),
        .idex_imm_o        (out_idex.imm),
        .idex_jmpLoc_o     (out_idex.jmpLoc),
        .idex_opcode_o     (out_idex.opcode),
        .idex_reg1_o       (out_idex.reg1),
        .idex_reg2_o       (out_idex.reg2),
        .idex_regD_o       (out_idex.regD),
        .exmem_write_mem_i (in_exmem.wm),
        .exmem_write_reg_i (in_exmem.wr),
        .exmem_read_mem_i  (in_exmem.rm),
        .exmem_aluOut_i    (in_exmem.aluOut),
        .exmem_data1_i     (in_exmem.data1),
        .exmem_data2_i     (in_exmem.data2),
        .exmem_dataD_i     (in_exmem.dataD),
        .exmem_imm_i       (in_exmem.imm),
        .exmem_opcode_i    (in_exmem.opcode),
        .exmem_reg1_i      (in_exmem.reg1),
        .exmem_reg2_i      (in_exmem.reg2),
        .exmem_regD_i      (in_exmem.regD),
        .exmem_write_mem_o (out_exmem.wm),
        .exmem_write_reg_o (out_exmem.wr),
        .exmem_read_mem_o  (out_exmem.rm),
        .exmem_aluOut_o    (out_exmem.aluOut),
        .exmem_data1_o     (out_exmem.data1),
        .exmem_data2_o     (out_exmem.data2),
        .exmem_dataD_o     (out_exmem.dataD),
        .exmem_imm_o       (out_exmem.imm),
        .exmem_opcode_o    (out_exmem.opcode),
        .exmem_reg1_o      (out_exmem.reg1),
        .exmem_reg2_o      (out_exmem.reg2),
        .exmem_regD_o      (out_exmem.regD)
    );

    function automatic idex_t idex_next(idex_t d, ifid_t p, logic ch);
        idex_t r;
        r = d;
        if (ch) begin
            r.imm    = p.imm;
            r.jmpLoc = p.jmpLoc;
            r.opcode = p.opcode;
            r.reg1   = p.reg1;
            r.reg2   = p.reg2;
            r.regD   = p.regD;
        end
        return r;
    endfunction

    function automatic exmem_t exmem_next(exmem_t d, idex_t p, logic ch);
        exmem_t r;
        r = d;
        if (ch) begin
            r.wm     = p.wm;
            r.wr     = p.wr;
            r.rm     = p.rm;
            r.data1  = p.data1;
            r.data2  = p.data2;
            r.dataD  = p.dataD;
            r.imm    = p.imm;
            r.opcode = p.opcode;
            r.reg1   = p.reg1;
            r.reg2   = p.reg2;
            r.regD   = p.regD;
        end
        return r;
    endfunction

    // Model: each bank shows what the stage feeding it offered at the last edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ifid  <= '0;
            m_idex  <= '0;
            m_exmem <= '0;
        end else begin
            m_ifid  <= drv_ifid;
            m_idex  <= idex_next(drv_idex, m_ifid, chain);
            m_exmem <= exmem_next(drv_exmem, m_idex, chain);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ifid_bank",  64'(out_ifid),  64'(m_ifid));
        chk("idex_bank",  64'(out_idex),  64'(m_idex));
        chk("exmem_bank", 64'(out_exmem), 64'(m_exmem));
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ifid_zero"},  64'(out_ifid),  64'd0);
        chk({tag, "_idex_zero"},  64'(out_idex),  64'd0);
        chk({tag, "_exmem_zero"}, 64'(out_exmem), 64'd0);
    endtask

    initial begin
        drv_ifid  = '1;
        drv_idex  = '1;
        drv_exmem = '1;

        // Reset held for three edges with all-ones inputs.
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_jmpLoc", 64'(out_ifid.jmpLoc),  64'h0000_0000_0000_FFFF);
        chk("release_data1",  64'(out_idex.data1),   64'h0000_0000_0000_00FF);
        chk("release_aluOut", 64'(out_exmem.aluOut), 64'h0000_0000_0000_00FF);

        // IF/ID capture, inputs disturbed mid-cycle.
        @(negedge clk);
        drv_ifid = '{opcode: 4'hA, format: 2'd1, imm: 3'd5, immFlag: 1'b1,
                     jmpLoc: 16'h1234, reg1: 3'd1, reg2: 3'd2, regD: 3'd3};
        @(posedge clk);
        #2;
        drv_ifid = '{opcode: 4'h7, format: 2'd2, imm: 3'd6, immFlag: 1'b0,
                     jmpLoc: 16'hBEEF, reg1: 3'd4, reg2: 3'd5, regD: 3'd6};
        #1;
        chk("ifid_opcode_A",  64'(out_ifid.opcode), 64'hA);
        chk("ifid_imm_5",     64'(out_ifid.imm),    64'd5);
        chk("ifid_jmp_1234",  64'(out_ifid.jmpLoc), 64'h1234);
        chk("ifid_regs_123",  64'({out_ifid.reg1, out_ifid.reg2, out_ifid.regD}),
            64'({3'd1, 3'd2, 3'd3}));
        @(posedge clk);
        #1;
        chk("ifid_opcode_7",  64'(out_ifid.opcode), 64'h7);
        chk("ifid_jmp_BEEF",  64'(out_ifid.jmpLoc), 64'hBEEF);

        // ID/EX control and data, then a bubble.
        @(negedge clk);
        drv_idex = '0;
        drv_idex.wr = 1'b1;
        drv_idex.rm = 1'b1;
        drv_idex.alu_op = 4'h6;
        drv_idex.data1 = 8'h3C;
        drv_idex.data2 = 8'hC3;
        drv_idex.dataD = 8'h80;
        @(posedge clk);
        #1;
        chk("idex_flags",  64'({out_idex.wm, out_idex.wr, out_idex.rm}), 64'b011);
        chk("idex_aluop",  64'(out_idex.alu_op), 64'h6);
        chk("idex_data",   64'({out_idex.data1, out_idex.data2, out_idex.dataD}), 64'h3CC380);
        @(negedge clk);
        drv_idex = '0;
        @(posedge clk);
        #1;
        chk("idex_bubble", 64'({out_idex.wm, out_idex.wr, out_idex.rm}), 64'b000);

        // Chained opcode sequence 1..4 reaches EX/MEM three edges after entry.
        @(negedge clk);
        drv_ifid  = '0;
        drv_idex  = '0;
        drv_exmem = '0;
        chain     = 1'b1;
        for (int j = 0; j < 7; j++) begin
            if (j > 0) @(negedge clk);
            if (j >= 3) chk("chain_opcode", 64'(out_exmem.opcode), 64'(j - 2));
            drv_ifid.opcode = (j < 4) ? 4'(j + 1) : 4'd0;
        end
        @(negedge clk);
        chain = 1'b0;

        // Asynchronous reset pulse between edges.
        drv_ifid  = '1;
        drv_idex  = '1;
        drv_exmem = '1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("pulse");
        #1;
        rst_n = 1'b1;
        #0.5;
        chk_all_zero("post_pulse");
        @(posedge clk);
        #1;
        chk("post_pulse_jmp", 64'(out_ifid.jmpLoc), 64'hFFFF);

        // Walking one through jmpLoc and aluOut.
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            drv_ifid  = '0;
            drv_exmem = '0;
            drv_ifid.jmpLoc   = 16'd1 << b;
            drv_exmem.aluOut  = 8'd1 << (b % 8);
            @(posedge clk);
            #1;
            chk("walk_jmpLoc", 64'(out_ifid.jmpLoc),   64'(16'd1 << b));
            chk("walk_aluOut", 64'(out_exmem.aluOut),  64'(8'd1 << (b % 8)));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
